inst_loader: RTL

Instruction-side counterpart to the core's fetch path: receives a program as a byte stream from the UART receiver, assembles little-endian 32-bit instruction words into an on-chip instruction RAM, then serves the core's fetch requests from that RAM. It sits between the UART RX block and the core's `instr` input. All decoder/exec stages consume only what this block returns.

---
 rtl/inst_loader_if.sv | 25 ++
 rtl/inst_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/inst_loader_if.sv
// Byte-stream load and instruction-fetch signal bundle for inst_loader.
interface inst_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                fetch_req;
   logic [31:0]         fetch_addr;
   logic                fetch_valid;
   logic [31:0]         fetch_data;
   logic                fetch_err;
   logic                load_done;
   logic                load_error;
   logic [ADDR_WIDTH:0] loaded_words;

   modport master (
      output rx_data, rx_valid, fetch_req, fetch_addr,
      input  fetch_valid, fetch_data, fetch_err, load_done, load_error, loaded_words
   );

   modport slave (
      input  rx_data, rx_valid, fetch_req, fetch_addr,
      output fetch_valid, fetch_data, fetch_err, load_done, load_error, loaded_words
   );
endinterface

// File: rtl/inst_loader.sv
// Loads a length-prefixed little-endian program from a byte stream into RAM, then serves fetches.
// Fetch latency 1 cycle; no backpressure on either side: bytes and requests are taken or dropped.
module inst_loader #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic         clk,
   input  logic         rstn,
   inst_loader_if.slave bus
);
   typedef enum logic [1:0] {s_len, s_load, s_serve, s_error} state_e;

   localparam int              DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [32:0]     DEPTH_EXT = 33'(1) << ADDR_WIDTH;

   state_e                state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           asm_q, asm_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic                  fetch_valid_q, fetch_valid_d;
   logic [31:0]           fetch_data_q, fetch_data_d;
   logic                  fetch_err_q, fetch_err_d;
   logic                  load_done_q, load_done_d;
   logic                  load_error_q, load_error_d;

   logic [31:0]           mem [DEPTH];
   logic                  mem_we;
   logic [31:0]           rx_word;
   logic                  word_done;
   logic                  hdr_too_big;
   logic [ADDR_WIDTH:0]   ptr_nxt;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  addr_bad;

   // Incoming byte completes the word; earlier three bytes sit in asm_q, oldest lowest.
   assign rx_word     = {bus.rx_data, asm_q};
   assign word_done   = bus.rx_valid && (byte_cnt_q == 2'd3);
   assign hdr_too_big = {1'b0, rx_word} > DEPTH_EXT;
   assign ptr_nxt     = {1'b0, ptr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign idx         = bus.fetch_addr[ADDR_WIDTH+1:2];
   assign addr_bad    = (bus.fetch_addr[1:0] != 2'b00) ||
                        (bus.fetch_addr[31:2] >= 30'(n_q));

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      asm_d         = asm_q;
      ptr_d         = ptr_q;
      n_d           = n_q;
      fetch_valid_d = 1'b0;
      fetch_data_d  = fetch_data_q;
      fetch_err_d   = fetch_err_q;
      load_done_d   = load_done_q;
      load_error_d  = load_error_q;
      mem_we        = 1'b0;

      case (state_q)
         s_len: begin
            if (bus.rx_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               asm_d      = {bus.rx_data, asm_q[23:8]};
            end
            if (word_done) begin
               byte_cnt_d = 2'd0;
               n_d        = rx_word[ADDR_WIDTH:0];
               if (hdr_too_big) begin
                  state_d      = s_error;
                  load_error_d = 1'b1;
               end else if (rx_word == 32'd0) begin
                  state_d     = s_serve;
                  load_done_d = 1'b1;
               end else begin
                  state_d = s_load;
                  ptr_d   = '0;
               end
            end
         end

         s_load: begin
            if (bus.rx_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               asm_d      = {bus.rx_data, asm_q[23:8]};
            end
            if (word_done) begin
               byte_cnt_d = 2'd0;
               mem_we     = 1'b1;
               ptr_d      = ptr_nxt[ADDR_WIDTH-1:0];
               if (ptr_nxt == n_q) begin
                  state_d     = s_serve;
                  load_done_d = 1'b1;
               end
            end
         end

         s_serve: begin
            if (bus.fetch_req) begin
               fetch_valid_d = 1'b1;
               fetch_err_d   = addr_bad;
               fetch_data_d  = addr_bad ? 32'd0 : mem[idx];
            end
         end

         s_error: begin
         end

         default: state_d = s_len;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= s_len;
         byte_cnt_q    <= 2'd0;
         asm_q         <= 24'd0;
         ptr_q         <= '0;
         n_q           <= '0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= 32'd0;
         fetch_err_q   <= 1'b0;
         load_done_q   <= 1'b0;
         load_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         asm_q         <= asm_d;
         ptr_q         <= ptr_d;
         n_q           <= n_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_data_q  <= fetch_data_d;
         fetch_err_q   <= fetch_err_d;
         load_done_q   <= load_done_d;
         load_error_q  <= load_error_d;
      end
   end

   // RAM is deliberately left out of reset; the bound check against n_q hides stale words.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ptr_q] <= rx_word;
      end
   end

   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.fetch_data   = fetch_data_q;
   assign bus.fetch_err    = fetch_err_q;
   assign bus.load_done    = load_done_q;
   assign bus.load_error   = load_error_q;
   assign bus.loaded_words = n_q;
endmodule
